fog_lut_stream_tx: RTL and testbench
====================================

# fog_lut_stream_tx

Transmitter for the fog function LUT stream: buffers a complete fog LUT (one bounds beat plus LUT_SIZE segment beats) written over a simple register port, then emits it on an AXI-Stream master on a start pulse. Sits between the command parser / register bank and the fog unit's LUT stream slave, so LUT reloads are decoupled from command traffic and tlast framing is generated in one place.

## Interface
- CMD_STREAM_WIDTH, 64, width of buffer words and of m_axis_tdata
- LUT_SIZE, 32, number of segment beats; total stream length is LUT_SIZE+1 beats
- aclk  in  1  clock, all logic on rising edge
- resetn  in  1  reset, asynchronous, active-low
- wr_en  in  1  buffer write strobe
- wr_ready  out  1  high when writes are accepted (== !busy)
- wr_addr  in  $clog2(LUT_SIZE+1)  word index; 0 = bounds beat, 1..LUT_SIZE = segments
- wr_data  in  CMD_STREAM_WIDTH  word; bounds beat = {upper[63:32], lower[31:0]}, segment = {m[63:32], b[31:0]}
- start  in  1  single-cycle request to stream the buffer
- busy  out  1  high from accepted start until final handshake completes
- done  out  1  one-cycle pulse the cycle after the final handshake
- m_axis_tvalid  out  1  beat valid
- m_axis_tready  in  1  sink ready
- m_axis_tlast  out  1  high on beat LUT_SIZE only
- m_axis_tdata  out  CMD_STREAM_WIDTH  beat payload

## Operation
- Buffer: LUT_SIZE+1 words, synchronous write when wr_en && wr_ready && wr_addr <= LUT_SIZE; addresses > LUT_SIZE ignored. Buffer contents not cleared by reset.
- Writes while busy are dropped (wr_ready low); the buffer is stable for the whole stream.
- FSM states IDLE, STREAM.
  - IDLE: tvalid=0, busy=0. start=1 -> load beat 0 into output register, tvalid=1, idx=0, go STREAM.
  - STREAM: on handshake (tvalid && tready): if idx==LUT_SIZE -> tvalid=0, done=1 next cycle, go IDLE; else idx+1, next word into output register, tvalid stays 1.
- start while busy is ignored (no queueing), including on the cycle of the final handshake.
- start coinciding with wr_en in IDLE: write takes effect, stream sends pre-write contents for that address only if it is beat 0; beats 1.. read the updated buffer.
- AXIS rules: tdata/tlast held stable while tvalid && !tready; tvalid never deasserted without a handshake except by reset.
- tlast = (idx == LUT_SIZE) && tvalid.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, done=0, wr_ready=1, FSM=IDLE, idx=0.
- start at edge N -> tvalid=1 with beat 0 after edge N (visible cycle N+1); busy high same cycle.
- Continuous tready: one beat per cycle, LUT_SIZE+1 cycles of tvalid, back-to-back with no bubbles.
- Final handshake at edge M -> tvalid=0, busy=0, done=1 in cycle M+1; done=0 in M+2. start in cycle M+1 accepted.
- Reset asserted mid-stream: outputs return to reset values immediately (asynchronous); partial frame is not completed; sink must resynchronise on its own reset.
- Backpressure of any length is tolerated; no timeout.

## Test plan
- Write words 0..32 with data = {32'(i), 32'(i+100)}, pulse start, tready=1 -> 33 beats on consecutive cycles, beat i tdata = {i, i+100}, tlast only on beat 32, done pulse one cycle after beat 32, busy low same cycle.
- Same stream with tready toggled 1,0,0,1 pattern -> tdata/tlast stable on stalled cycles, all 33 beats in order, no duplicate or skipped beat.
- While streaming, wr_en with wr_addr=5, wr_data=64'hDEAD -> wr_ready=0, write dropped; second stream shows original word 5.
- start asserted at beat 10 and again on final handshake cycle -> ignored; exactly one 33-beat frame; start in cycle after done -> new frame begins next cycle.
- wr_addr=33 write with 64'hFFFF -> no buffer change, no error; subsequent stream unchanged.
- resetn pulled low at beat 17 with tready=1 -> tvalid, tlast, busy, done low asynchronously; after release, start yields full frame from beat 0 with buffer contents retained.

Source files
------------

// File: rtl/fog_lut_stream_tx.sv
// fog_lut_stream_tx: buffers one fog LUT frame (bounds + segments) and replays it on an AXI-Stream master on start
module fog_lut_stream_tx #(
   parameter int CMD_STREAM_WIDTH = 64,
   parameter int LUT_SIZE = 32
) (
   input  logic                          aclk,
   input  logic                          resetn,
   input  logic                          wr_en,
   output logic                          wr_ready,
   input  logic [$clog2(LUT_SIZE+1)-1:0] wr_addr,
   input  logic [CMD_STREAM_WIDTH-1:0]   wr_data,
   input  logic                          start,
   output logic                          busy,
   output logic                          done,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tlast,
   output logic [CMD_STREAM_WIDTH-1:0]   m_axis_tdata
);
   localparam int AW = $clog2(LUT_SIZE+1);
   typedef enum logic {IDLE, STREAM} state_t;
   state_t state, state_d;
   logic [AW-1:0] idx, idx_d;
   logic [CMD_STREAM_WIDTH-1:0] tdata_d;
   logic done_d, last, hs;
   logic [CMD_STREAM_WIDTH-1:0] mem [LUT_SIZE+1];
   assign busy = state == STREAM;
   assign wr_ready = !busy;
   assign m_axis_tvalid = busy;
   assign last = idx == AW'(LUT_SIZE);
   assign m_axis_tlast = last && m_axis_tvalid;
   assign hs = m_axis_tvalid && m_axis_tready;
   // the buffer is frozen while streaming, so each beat reads it directly
   always_ff @(posedge aclk)
      if (wr_en && wr_ready && wr_addr <= AW'(LUT_SIZE)) mem[wr_addr] <= wr_data;
   always_comb begin
      state_d = state;
      idx_d = idx;
      tdata_d = m_axis_tdata;
      done_d = 1'b0;
      if (state == IDLE && start) begin
         state_d = STREAM;
         idx_d = '0;
         tdata_d = mem[0];
      end else if (hs && last) begin
         state_d = IDLE;
         idx_d = '0;
         done_d = 1'b1;
      end else if (hs) begin
         idx_d = idx + AW'(1);
         tdata_d = mem[idx + AW'(1)];
      end
   end
   always_ff @(posedge aclk or negedge resetn)
      if (!resetn) begin
         state <= IDLE;
         idx <= '0;
         m_axis_tdata <= '0;
         done <= 1'b0;
      end else begin
         state <= state_d;
         idx <= idx_d;
         m_axis_tdata <= tdata_d;
         done <= done_d;
      end
endmodule

// File: tb/tb_fog_lut_stream_tx.sv
// tb_fog_lut_stream_tx: randomized frame checks against a buffer-array model of the LUT stream
module tb_fog_lut_stream_tx;
   localparam int L = 32;
   logic aclk = 0, resetn = 0, wr_en = 0, start = 0, m_axis_tready = 0;
   logic [5:0] wr_addr = 0;
   logic [63:0] wr_data = 0;
   logic wr_ready, busy, done, m_axis_tvalid, m_axis_tlast;
   logic [63:0] m_axis_tdata;
   int total = 0, bad = 0;
   logic [63:0] ref_buf [0:L];
   logic [63:0] exp_w [0:L];
   logic [63:0] o_data [0:299];
   logic o_valid [0:299], o_last [0:299], o_ready [0:299], o_busy [0:299], o_done [0:299], o_wrr [0:299];
   bit start_at [0:299];
   int wr_cycle = -1;
   logic [5:0] wr_a;
   logic [63:0] wr_d;
   logic [63:0] hs_data [$];
   bit hs_last [$];
   int hs_cyc [$], done_cyc [$];
   int proto_bad;

   fog_lut_stream_tx #(.CMD_STREAM_WIDTH(64), .LUT_SIZE(L)) dut (
      .aclk(aclk), .resetn(resetn), .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr),
      .wr_data(wr_data), .start(start), .busy(busy), .done(done), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tdata(m_axis_tdata)
   );

   always #5 aclk = ~aclk;

   task automatic wr(input logic [5:0] a, input logic [63:0] d);
      @(negedge aclk);
      wr_en = 1; wr_addr = a; wr_data = d;
      @(negedge aclk);
      wr_en = 0;
      if (a <= 6'(L)) ref_buf[a] = d;
   endtask

   task automatic snap();
      for (int i = 0; i <= L; i++) exp_w[i] = ref_buf[i];
   endtask

   // cycle 0 records the idle state and drives start; mode 0 = tready high, 1 = 1,0,0,1 pattern, 2 = random
   task automatic run(input int n, input int mode);
      start_at[0] = 1;
      for (int k = 0; k < n; k++) begin
         @(negedge aclk);
         o_valid[k] = m_axis_tvalid; o_last[k] = m_axis_tlast; o_data[k] = m_axis_tdata;
         o_busy[k] = busy; o_done[k] = done; o_wrr[k] = wr_ready;
         start = start_at[k];
         wr_en = (k == wr_cycle); wr_addr = wr_a; wr_data = wr_d;
         m_axis_tready = mode == 0 ? 1'b1 : mode == 1 ? (k % 4 == 0 || k % 4 == 3) : ($urandom_range(3) != 0);
         o_ready[k] = m_axis_tready;
      end
      @(negedge aclk);
      start = 0; wr_en = 0; m_axis_tready = 0; wr_cycle = -1;
      for (int k = 0; k < 300; k++) start_at[k] = 0;
      hs_data.delete(); hs_last.delete(); hs_cyc.delete(); done_cyc.delete(); proto_bad = 0;
      for (int k = 0; k < n; k++) begin
         if (o_valid[k] && o_ready[k]) begin
            hs_data.push_back(o_data[k]); hs_last.push_back(o_last[k]); hs_cyc.push_back(k);
         end
         if (o_done[k]) done_cyc.push_back(k);
         if (o_busy[k] !== o_valid[k] || (o_last[k] && !o_valid[k]) || (o_done[k] && o_valid[k])) proto_bad++;
         if (k > 0 && o_valid[k-1] && !o_ready[k-1] &&
             (!o_valid[k] || o_data[k] !== o_data[k-1] || o_last[k] !== o_last[k-1])) proto_bad++;
      end
   endtask

   task automatic test_reset();
      total += 6;
      if (m_axis_tvalid !== 0) begin bad++; $display("FAIL reset_tvalid got=%b want=0", m_axis_tvalid); end
      if (m_axis_tlast !== 0) begin bad++; $display("FAIL reset_tlast got=%b want=0", m_axis_tlast); end
      if (m_axis_tdata !== 0) begin bad++; $display("FAIL reset_tdata got=%h want=0", m_axis_tdata); end
      if (busy !== 0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      if (done !== 0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
      if (wr_ready !== 1) begin bad++; $display("FAIL reset_wr_ready got=%b want=1", wr_ready); end
   endtask

   task automatic test_continuous();
      for (int i = 0; i <= L; i++) wr(6'(i), {32'(i), 32'(i + 100)});
      snap();
      run(36, 0);
      total++;
      if (hs_data.size() !== L + 1) begin bad++; $display("FAIL cont_len got=%0d want=%0d", hs_data.size(), L + 1); end
      for (int i = 0; i <= L && i < hs_data.size(); i++) begin
         total++;
         if (hs_data[i] !== exp_w[i] || hs_last[i] !== (i == L) || hs_cyc[i] !== i + 1) begin
            bad++; $display("FAIL cont_beat%0d data=%h last=%b cyc=%0d want=%h last=%b cyc=%0d",
                            i, hs_data[i], hs_last[i], hs_cyc[i], exp_w[i], i == L, i + 1);
         end
      end
      total++;
      if (done_cyc.size() !== 1 || done_cyc[0] !== L + 2) begin
         bad++; $display("FAIL cont_done count=%0d cyc=%0d want count=1 cyc=%0d", done_cyc.size(), done_cyc[0], L + 2);
      end
      total++;
      if (o_busy[1] !== 1 || o_busy[L + 2] !== 0) begin
         bad++; $display("FAIL cont_busy first=%b atdone=%b want 1 0", o_busy[1], o_busy[L + 2]);
      end
      total++;
      if (proto_bad !== 0) begin bad++; $display("FAIL cont_protocol got=%0d want=0", proto_bad); end
   endtask

   task automatic test_backpressure(input int mode);
      snap();
      run(mode == 1 ? 80 : 160, mode);
      total++;
      if (hs_data.size() !== L + 1) begin bad++; $display("FAIL bp%0d_len got=%0d want=%0d", mode, hs_data.size(), L + 1); end
      for (int i = 0; i <= L && i < hs_data.size(); i++) begin
         total++;
         if (hs_data[i] !== exp_w[i] || hs_last[i] !== (i == L)) begin
            bad++; $display("FAIL bp%0d_beat%0d data=%h last=%b want=%h last=%b", mode, i, hs_data[i], hs_last[i], exp_w[i], i == L);
         end
      end
      total++;
      if (done_cyc.size() !== 1 || hs_cyc.size() < L + 1 || done_cyc[0] !== hs_cyc[L] + 1) begin
         bad++; $display("FAIL bp%0d_done count=%0d cyc=%0d want one pulse after final handshake", mode, done_cyc.size(), done_cyc[0]);
      end
      total++;
      if (proto_bad !== 0) begin bad++; $display("FAIL bp%0d_protocol got=%0d want=0", mode, proto_bad); end
   endtask

   task automatic test_write_while_busy();
      snap();
      wr_cycle = 5; wr_a = 5; wr_d = 64'hDEAD;
      run(36, 0);
      total++;
      if (o_wrr[5] !== 0) begin bad++; $display("FAIL busy_wr_ready got=%b want=0", o_wrr[5]); end
      snap();
      run(36, 0);
      total++;
      if (hs_data.size() !== L + 1 || hs_data[5] !== exp_w[5]) begin
         bad++; $display("FAIL busy_wr_dropped word5=%h want=%h", hs_data[5], exp_w[5]);
      end
   endtask

   task automatic test_start_ignored();
      snap();
      start_at[11] = 1; start_at[L + 1] = 1; start_at[L + 2] = 1;
      run(2 * L + 6, 0);
      total++;
      if (hs_data.size() !== 2 * (L + 1)) begin bad++; $display("FAIL restart_len got=%0d want=%0d", hs_data.size(), 2 * (L + 1)); end
      for (int i = 0; i < 2 * (L + 1) && i < hs_data.size(); i++) begin
         total++;
         if (hs_data[i] !== exp_w[i % (L + 1)] || hs_cyc[i] !== (i <= L ? i + 1 : i + 2)) begin
            bad++; $display("FAIL restart_beat%0d data=%h cyc=%0d want=%h cyc=%0d", i, hs_data[i], hs_cyc[i],
                            exp_w[i % (L + 1)], i <= L ? i + 1 : i + 2);
         end
      end
      total++;
      if (done_cyc.size() !== 2 || done_cyc[0] !== L + 2 || done_cyc[1] !== 2 * L + 4) begin
         bad++; $display("FAIL restart_done count=%0d first=%0d want count=2 first=%0d", done_cyc.size(), done_cyc[0], L + 2);
      end
   endtask

   task automatic test_start_with_write();
      for (int t = 0; t < 2; t++) begin
         snap();
         wr_cycle = 0; wr_a = t == 0 ? 6'd0 : 6'd7; wr_d = {$urandom, $urandom};
         if (t == 1) exp_w[7] = wr_d;
         run(36, 0);
         ref_buf[wr_a] = wr_d;
         total++;
         if (hs_data.size() !== L + 1 || hs_data[wr_a] !== exp_w[wr_a]) begin
            bad++; $display("FAIL startwr_addr%0d got=%h want=%h", wr_a, hs_data[wr_a], exp_w[wr_a]);
         end
      end
      snap();
      run(36, 0);
      total++;
      if (hs_data.size() !== L + 1 || hs_data[0] !== exp_w[0]) begin
         bad++; $display("FAIL startwr_followup word0=%h want=%h", hs_data[0], exp_w[0]);
      end
   endtask

   task automatic test_bad_addr();
      wr(6'd33, 64'hFFFF);
      wr(6'($urandom_range(63, 34)), {$urandom, $urandom});
      snap();
      run(36, 0);
      total++;
      if (hs_data.size() !== L + 1) begin bad++; $display("FAIL badaddr_len got=%0d want=%0d", hs_data.size(), L + 1); end
      for (int i = 0; i <= L && i < hs_data.size(); i++) begin
         total++;
         if (hs_data[i] !== exp_w[i]) begin bad++; $display("FAIL badaddr_beat%0d got=%h want=%h", i, hs_data[i], exp_w[i]); end
      end
   endtask

   task automatic test_random_writes();
      repeat (20) wr(6'($urandom_range(L)), {$urandom, $urandom});
      test_backpressure(2);
   endtask

   task automatic test_reset_mid();
      snap();
      @(negedge aclk); start = 1; m_axis_tready = 1;
      @(negedge aclk); start = 0;
      repeat (17) @(negedge aclk);
      total++;
      if (m_axis_tdata !== exp_w[17] || m_axis_tvalid !== 1) begin
         bad++; $display("FAIL rst_mid_beat17 got=%h v=%b want=%h v=1", m_axis_tdata, m_axis_tvalid, exp_w[17]);
      end
      #2 resetn = 0;
      #1 test_reset();
      @(negedge aclk); resetn = 1; m_axis_tready = 0;
      run(36, 0);
      total++;
      if (hs_data.size() !== L + 1) begin bad++; $display("FAIL rst_mid_len got=%0d want=%0d", hs_data.size(), L + 1); end
      for (int i = 0; i <= L && i < hs_data.size(); i++) begin
         total++;
         if (hs_data[i] !== exp_w[i] || hs_last[i] !== (i == L)) begin
            bad++; $display("FAIL rst_mid_beat%0d got=%h last=%b want=%h last=%b", i, hs_data[i], hs_last[i], exp_w[i], i == L);
         end
      end
   endtask

   initial begin
      repeat (3) @(negedge aclk);
      test_reset();
      resetn = 1;
      test_continuous();
      test_backpressure(1);
      test_write_while_busy();
      test_start_ignored();
      test_start_with_write();
      test_bad_addr();
      test_random_writes();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
